ddr_refresh_scheduler: RTL and testbench

//   Generates DDR4 auto-refresh timing: counts tREFI, accrues postponed-refresh

---
 rtl/ddr_refresh_scheduler_if.sv | 46 ++++
 rtl/ddr_refresh_scheduler.sv | 129 ++++++++++++
 tb/tb_ddr_refresh_scheduler.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_refresh_scheduler_if.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// ddr_refresh_scheduler_if: controller <-> refresh scheduler handshake bundle
// Revision: 1.0
//==============================================================================
interface ddr_refresh_scheduler_if #(
  parameter int MAX_POSTPONE = 8
);
  localparam int CW = $clog2(MAX_POSTPONE + 1);

  logic          enable;
  logic          rw_idle;
  logic          refresh_req;
  logic          refresh_urgent;
  logic          ref_cmd;
  logic          refresh_active;
  logic          refresh_done;
  logic [CW-1:0] credits;
  logic          ref_overflow;

  modport master (
    output enable,
    output rw_idle,
    input  refresh_req,
    input  refresh_urgent,
    input  ref_cmd,
    input  refresh_active,
    input  refresh_done,
    input  credits,
    input  ref_overflow
  );

  modport slave (
    input  enable,
    input  rw_idle,
    output refresh_req,
    output refresh_urgent,
    output ref_cmd,
    output refresh_active,
    output refresh_done,
    output credits,
    output ref_overflow
  );
endinterface
`default_nettype wire

// File: rtl/ddr_refresh_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// ddr_refresh_scheduler: DDR4 tREFI/tRFC auto-refresh scheduler with credits
// Revision: 1.0
//==============================================================================
module ddr_refresh_scheduler #(
  parameter int T_REFI       = 7800,
  parameter int T_RFC        = 350,
  parameter int MAX_POSTPONE = 8,
  parameter int URGENT_LVL   = 6
) (
  input  logic                    clock_t,
  input  logic                    reset_n,
  ddr_refresh_scheduler_if.slave  ctl
);

  localparam int CW = $clog2(MAX_POSTPONE + 1);
  localparam int IW = $clog2(T_REFI);
  localparam int RW = $clog2(T_RFC);

  localparam logic [IW-1:0] C_REFI_LAST = IW'(T_REFI - 1);
  localparam logic [RW-1:0] C_RFC_LAST  = RW'(T_RFC - 2);
  localparam logic [CW-1:0] C_CMAX      = CW'(MAX_POSTPONE);
  localparam logic [CW-1:0] C_CURG      = CW'(URGENT_LVL);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_RFC   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] refi_cnt;
  logic [RW-1:0] rfc_cnt;
  logic [CW-1:0] credits;
  logic          overflow;
  logic          tick;
  logic          ref_cmd;
  logic          rfc_last;

  assign tick     = ctl.enable && (refi_cnt == C_REFI_LAST);
  assign ref_cmd  = (state == S_ISSUE);
  assign rfc_last = (state == S_RFC) && (rfc_cnt == C_RFC_LAST);

  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      refi_cnt <= '0;
    end else if (!ctl.enable || tick) begin
      refi_cnt <= '0;
    end else begin
      refi_cnt <= refi_cnt + IW'(1);
    end
  end

  // A REF issued in the same cycle as a tick cancels the tick's new credit.
  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      credits  <= '0;
      overflow <= 1'b0;
    end else begin
      if (tick && (credits == C_CMAX)) begin
        overflow <= 1'b1;
      end
      if (!ctl.enable) begin
        credits <= '0;
      end else if (tick && !ref_cmd) begin
        if (credits != C_CMAX) begin
          credits <= credits + CW'(1);
        end
      end else if (ref_cmd && !tick) begin
        credits <= credits - CW'(1);
      end
    end
  end

  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      rfc_cnt <= '0;
    end else if (state == S_ISSUE) begin
      rfc_cnt <= '0;
    end else if (state == S_RFC) begin
      rfc_cnt <= rfc_cnt + RW'(1);
    end
  end

  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_OFF;
    end else begin
      state <= state_nxt;
    end
  end

  // An issued REF always runs its full tRFC, even if enable drops meanwhile.
  always_comb begin
    state_nxt = state;
    case (state)
      S_OFF: begin
        if (ctl.enable) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!ctl.enable)                              state_nxt = S_OFF;
        else if ((credits != '0) && ctl.rw_idle)      state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        state_nxt = S_RFC;
      end
      S_RFC: begin
        if (rfc_last) state_nxt = ctl.enable ? S_WAIT : S_OFF;
      end
      default: begin
        state_nxt = S_OFF;
      end
    endcase
  end

  assign ctl.refresh_req    = (credits != '0);
  assign ctl.refresh_urgent = (credits >= C_CURG);
  assign ctl.ref_cmd        = ref_cmd;
  assign ctl.refresh_active = (state == S_ISSUE) || (state == S_RFC);
  assign ctl.refresh_done   = rfc_last;
  assign ctl.credits        = credits;
  assign ctl.ref_overflow   = overflow;

endmodule
`default_nettype wire

// File: tb/tb_ddr_refresh_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// tb_ddr_refresh_scheduler: vector table plus scoreboarded refresh sequences
// Revision: 1.0
//==============================================================================
module tb_ddr_refresh_scheduler;

  localparam int T_REFI       = 20;
  localparam int T_RFC        = 5;
  localparam int MAX_POSTPONE = 4;
  localparam int URGENT_LVL   = 3;

  typedef struct {
    int adv;
    bit en;
    bit idle;
    bit req;
    bit urg;
    bit cmd;
    bit act;
    bit done;
    int cr;
    bit ovf;
  } vec_t;

  typedef struct {
    bit req;
    bit urg;
    bit cmd;
    bit act;
    bit done;
    int cr;
    bit ovf;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   base  = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  exp_t exp_q[$];
  int   ref_q[$];
  int   exp_ref_q[$];
  vec_t tv[7];

  ddr_refresh_scheduler_if #(.MAX_POSTPONE(MAX_POSTPONE)) ifc ();

  ddr_refresh_scheduler #(
    .T_REFI       (T_REFI),
    .T_RFC        (T_RFC),
    .MAX_POSTPONE (MAX_POSTPONE),
    .URGENT_LVL   (URGENT_LVL)
  ) dut (
    .clock_t (clk),
    .reset_n (rst_n),
    .ctl     (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (ifc.ref_cmd === 1'b1) ref_q.push_back(cyc);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, summary %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (rel cycle %0d)", name, act, expv, cyc - base);
  endtask

  function automatic exp_t mk(input bit req, input bit urg, input bit cmd, input bit act,
                              input bit done, input int cr, input bit ovf);
    exp_t e;
    e.req = req; e.urg = urg; e.cmd = cmd; e.act = act;
    e.done = done; e.cr = cr; e.ovf = ovf;
    return e;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_after(input string tag, input int n, input exp_t e);
    exp_t w;
    exp_q.push_back(e);
    step(n);
    w = exp_q.pop_front();
    chk({tag, ".req"},  ifc.refresh_req,    w.req);
    chk({tag, ".urg"},  ifc.refresh_urgent, w.urg);
    chk({tag, ".cmd"},  ifc.ref_cmd,        w.cmd);
    chk({tag, ".act"},  ifc.refresh_active, w.act);
    chk({tag, ".done"}, ifc.refresh_done,   w.done);
    chk({tag, ".cr"},   ifc.credits,        w.cr);
    chk({tag, ".ovf"},  ifc.ref_overflow,   w.ovf);
  endtask

  task automatic check_refs(input string tag);
    chk({tag, ".ref_count"}, ref_q.size(), exp_ref_q.size());
    while (ref_q.size() > 0 && exp_ref_q.size() > 0)
      chk({tag, ".ref_cycle"}, ref_q.pop_front() - base, exp_ref_q.pop_front());
    ref_q.delete();
    exp_ref_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ifc.enable  = 1'b0;
    ifc.rw_idle = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    ref_q.delete();
    exp_ref_q.delete();
    exp_q.delete();
  endtask

  task automatic start(input bit idle);
    ifc.enable  = 1'b1;
    ifc.rw_idle = idle;
    base = cyc;
  endtask

  initial begin
    ifc.enable  = 1'b0;
    ifc.rw_idle = 1'b0;

    //        adv en idle req urg cmd act done cr ovf
    tv[0] = '{0,  1, 1,   0,  0,  0,  0,  0,   0, 0};
    tv[1] = '{19, 1, 1,   0,  0,  0,  0,  0,   0, 0};
    tv[2] = '{1,  1, 1,   1,  0,  0,  0,  0,   1, 0};
    tv[3] = '{1,  1, 1,   1,  0,  1,  1,  0,   1, 0};
    tv[4] = '{1,  1, 1,   0,  0,  0,  1,  0,   0, 0};
    tv[5] = '{3,  1, 1,   0,  0,  0,  1,  1,   0, 0};
    tv[6] = '{1,  1, 1,   0,  0,  0,  0,  0,   0, 0};

    // Single refresh: tick 19, req 20, REF 21, done 25
    do_reset();
    base = cyc;
    exp_ref_q = '{21};
    foreach (tv[i]) begin
      ifc.enable  = tv[i].en;
      ifc.rw_idle = tv[i].idle;
      expect_after($sformatf("t1.v%0d", i), tv[i].adv,
                   mk(tv[i].req, tv[i].urg, tv[i].cmd, tv[i].act, tv[i].done, tv[i].cr, tv[i].ovf));
    end
    check_refs("t1");

    // Credits accrue while blocked, saturate, overflow, then drain
    do_reset();
    start(1'b0);
    expect_after("t2.c0", 19, mk(0, 0, 0, 0, 0, 0, 0));
    expect_after("t2.c1", 1,  mk(1, 0, 0, 0, 0, 1, 0));
    expect_after("t2.c2", 20, mk(1, 0, 0, 0, 0, 2, 0));
    expect_after("t2.c3", 20, mk(1, 1, 0, 0, 0, 3, 0));
    step(10);
    check_refs("t2");
    expect_after("t3.sat",  10, mk(1, 1, 0, 0, 0, 4, 0));
    expect_after("t3.full", 19, mk(1, 1, 0, 0, 0, 4, 0));
    ifc.rw_idle = 1'b1;
    exp_ref_q = '{100, 106, 112, 118};
    expect_after("t3.ovf",     1,  mk(1, 1, 1, 1, 0, 4, 1));
    expect_after("t3.drained", 19, mk(0, 0, 0, 1, 0, 0, 1));
    ifc.rw_idle = 1'b0;
    expect_after("t3.sticky",  10, mk(1, 0, 0, 0, 0, 1, 1));
    check_refs("t3");

    // REF coincides with tick: credit count holds, second REF 6 cycles later
    do_reset();
    start(1'b0);
    expect_after("t4.pre", 38, mk(1, 0, 0, 0, 0, 1, 0));
    ifc.rw_idle = 1'b1;
    exp_ref_q = '{39, 45};
    expect_after("t4.ref_tick", 1, mk(1, 0, 1, 1, 0, 1, 0));
    expect_after("t4.hold",     1, mk(1, 0, 0, 1, 0, 1, 0));
    expect_after("t4.ref2",     5, mk(1, 0, 1, 1, 0, 1, 0));
    expect_after("t4.drain",    1, mk(0, 0, 0, 1, 0, 0, 0));
    check_refs("t4");

    // Enable drops on second RFC cycle: tRFC completes, then OFF
    do_reset();
    start(1'b1);
    expect_after("t5.rfc2", 23, mk(0, 0, 0, 1, 0, 0, 0));
    ifc.enable = 1'b0;
    expect_after("t5.done", 2, mk(0, 0, 0, 1, 1, 0, 0));
    expect_after("t5.off",  1, mk(0, 0, 0, 0, 0, 0, 0));
    step(4);
    ifc.enable = 1'b1;
    expect_after("t5.restart", 19, mk(0, 0, 0, 0, 0, 0, 0));
    exp_ref_q = '{21};
    check_refs("t5");
    expect_after("t5.tick", 1, mk(1, 0, 0, 0, 0, 1, 0));

    // Async reset in the middle of tRFC
    do_reset();
    start(1'b0);
    expect_after("t6.c2", 40, mk(1, 0, 0, 0, 0, 2, 0));
    ifc.rw_idle = 1'b1;
    expect_after("t6.issue", 1, mk(1, 0, 1, 1, 0, 2, 0));
    expect_after("t6.rfc",   2, mk(1, 0, 0, 1, 0, 1, 0));
    #2 rst_n = 1'b0;
    #1;
    expect_after("t6.async", 0, mk(0, 0, 0, 0, 0, 0, 0));
    ifc.enable  = 1'b0;
    ifc.rw_idle = 1'b0;
    step(2);
    rst_n = 1'b1;
    start(1'b0);
    expect_after("t6.c0", 19, mk(0, 0, 0, 0, 0, 0, 0));
    expect_after("t6.c1", 1,  mk(1, 0, 0, 0, 0, 1, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
